led_scan_scheduler: RTL and testbench

Column-scan sequencer for the 8x8 LED matrix driver. It sets the active column, the per-column blanking (de-ghost) window and a brightness PWM on-window, and sets when the shift-chain contents transfer into the display buffer. Frame-buffer swaps are deferred to the frame boundary so a frame is never torn. It sits between the host strobe input and the column mux/decoder and buffer-latch logic.

---
 rtl/led_scan_scheduler.sv | 146 ++++++++++++++
 tb/tb_led_scan_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_scheduler.sv
// Column-scan sequencer for an NCOLS-column LED matrix.
// Steps a column/slot counter pair while enabled, opens a brightness-sized
// drive window after a short blanking gap in every slot, and turns a host
// swap request into one buffer-latch command at the next frame boundary.
// All outputs are decoded from the current state, so they change only on
// clock edges or on reset.
module led_scan_scheduler #(
  parameter int NCOLS        = 8,
  parameter int SLOT_CYCLES  = 32,
  parameter int BLANK_CYCLES = 2,
  parameter int BRIGHT_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     strobe_req,
  input  logic [BRIGHT_W-1:0]      brightness,
  output logic [$clog2(NCOLS)-1:0] col_idx,
  output logic [NCOLS-1:0]         col_onehot,
  output logic                     drive_en,
  output logic                     latch_pulse,
  output logic                     frame_start,
  output logic                     swap_pending
);

  localparam int CW     = $clog2(NCOLS);
  localparam int SW     = $clog2(SLOT_CYCLES);
  localparam int MAX_ON = SLOT_CYCLES - BLANK_CYCLES;

  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(NCOLS - 1);
  localparam logic [SW-1:0] MAX_ON_S  = SW'(MAX_ON);
  localparam logic [SW-1:0] BLANK_S   = SW'(BLANK_CYCLES);

  logic          run_q,     run_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic          pending_q, pending_d;
  logic [SW-1:0] bright_q,  bright_d;

  logic [31:0]   bright_ext_s;
  logic [SW-1:0] bright_clamp_s;
  logic          slot_last_s;
  logic          frame_start_s;
  logic          latch_s;
  logic          drive_s;

  // Brightness is limited to the number of cycles left after blanking.
  always_comb begin
    bright_ext_s = 32'(brightness);
    if (bright_ext_s > 32'(MAX_ON)) begin
      bright_clamp_s = MAX_ON_S;
    end else begin
      bright_clamp_s = bright_ext_s[SW-1:0];
    end
  end

  // Output decode from the current state: column select, drive window, markers.
  always_comb begin
    slot_last_s   = (slot_cnt_q == SLOT_LAST);
    frame_start_s = run_q && (col_cnt_q == {CW{1'b0}}) && (slot_cnt_q == {SW{1'b0}});
    latch_s       = frame_start_s && pending_q;
    drive_s       = 1'b0;
    if (run_q && (slot_cnt_q >= BLANK_S)) begin
      drive_s = ((slot_cnt_q - BLANK_S) < bright_q);
    end else begin
      drive_s = 1'b0;
    end
    col_idx      = col_cnt_q;
    drive_en     = drive_s;
    frame_start  = frame_start_s;
    latch_pulse  = latch_s;
    swap_pending = pending_q;
    if (drive_s) begin
      col_onehot = NCOLS'(1) << col_cnt_q;
    end else begin
      col_onehot = {NCOLS{1'b0}};
    end
  end

  // Next-state: scan counters, per-slot brightness capture, swap request flag.
  always_comb begin
    run_d      = run_q;
    col_cnt_d  = col_cnt_q;
    slot_cnt_d = slot_cnt_q;
    bright_d   = bright_q;
    pending_d  = pending_q;

    if (!enable) begin
      run_d      = 1'b0;
      col_cnt_d  = {CW{1'b0}};
      slot_cnt_d = {SW{1'b0}};
    end else begin
      run_d = 1'b1;
      // The very first enabled edge only starts the scan; column 0 slot 0 follows.
      if (run_q) begin
        if (slot_last_s) begin
          slot_cnt_d = {SW{1'b0}};
          if (col_cnt_q == COL_LAST) begin
            col_cnt_d = {CW{1'b0}};
          end else begin
            col_cnt_d = col_cnt_q + CW'(1);
          end
        end else begin
          slot_cnt_d = slot_cnt_q + SW'(1);
        end
      end else begin
        slot_cnt_d = slot_cnt_q;
      end
    end

    // Sampled only at slot boundaries so a slot never changes width mid-way.
    if (!run_q || slot_last_s) begin
      bright_d = bright_clamp_s;
    end else begin
      bright_d = bright_q;
    end

    // A new request outranks the latch that would otherwise retire it.
    if (strobe_req) begin
      pending_d = 1'b1;
    end else if (latch_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q      <= 1'b0;
      col_cnt_q  <= {CW{1'b0}};
      slot_cnt_q <= {SW{1'b0}};
      pending_q  <= 1'b0;
      bright_q   <= {SW{1'b0}};
    end else begin
      run_q      <= run_d;
      col_cnt_q  <= col_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      pending_q  <= pending_d;
      bright_q   <= bright_d;
    end
  end

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Bench for led_scan_scheduler: a time-based reference model (cycles since
// scan start) checked against the DUT every cycle, plus directed literal
// expectations at hand-computed scan positions.
module tb_led_scan_scheduler;

  localparam int NCOLS = 8;
  localparam int SLOT  = 32;
  localparam int BLANK = 2;
  localparam int MAXON = SLOT - BLANK;
  localparam int FRAME = NCOLS * SLOT;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       strobe_req;
  logic [7:0] brightness;
  logic [2:0] col_idx;
  logic [7:0] col_onehot;
  logic       drive_en;
  logic       latch_pulse;
  logic       frame_start;
  logic       swap_pending;

  int tests = 0;
  int fails = 0;
  int tpos  = 0;
  int latch_cnt = 0;

  // Reference model state.
  bit m_run;
  int m_t;
  int m_bright;
  bit m_pend;
  int m_slot;
  bit m_frame;
  bit m_latch;

  led_scan_scheduler #(
    .NCOLS(NCOLS), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .BRIGHT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .strobe_req(strobe_req),
    .brightness(brightness), .col_idx(col_idx), .col_onehot(col_onehot),
    .drive_en(drive_en), .latch_pulse(latch_pulse), .frame_start(frame_start),
    .swap_pending(swap_pending)
  );

  always #5 clk = ~clk;

  // Model: m_t counts cycles since the scan started; column and slot follow from it.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 1'b0; m_t = 0; m_bright = 0; m_pend = 1'b0;
    end else begin
      m_slot  = m_t % SLOT;
      m_frame = m_run && ((m_t % FRAME) == 0);
      m_latch = m_frame && m_pend;
      if (!m_run || m_slot == SLOT - 1)
        m_bright = (int'(brightness) > MAXON) ? MAXON : int'(brightness);
      if (strobe_req) m_pend = 1'b1;
      else if (m_latch) m_pend = 1'b0;
      if (enable) begin
        if (m_run) m_t = m_t + 1;
        m_run = 1'b1;
      end else begin
        m_run = 1'b0;
        m_t = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int col, slot, onehot;
    bit drv, fr, lat;
    logic [13:0] exp_v, act_v;
    col  = (m_t / SLOT) % NCOLS;
    slot = m_t % SLOT;
    drv  = m_run && (slot >= BLANK) && ((slot - BLANK) < m_bright);
    fr   = m_run && ((m_t % FRAME) == 0);
    lat  = fr && m_pend;
    onehot = drv ? (1 << col) : 0;
    exp_v = {3'(col), 8'(onehot), drv, lat, fr};
    act_v = {col_idx, col_onehot, drive_en, latch_pulse, frame_start};
    tests++;
    if (exp_v !== act_v || swap_pending !== m_pend) begin
      fails++;
      $display("FAIL cycle_model t=%0d: got col=%0d oh=%h drv=%b lat=%b fs=%b sp=%b, expected col=%0d oh=%h drv=%b lat=%b fs=%b sp=%b",
               m_t, col_idx, col_onehot, drive_en, latch_pulse, frame_start, swap_pending,
               col, 8'(onehot), drv, lat, fr, m_pend);
    end
  end

  // Counts latch commands for the collapse check.
  always @(negedge clk) begin
    if (latch_pulse) latch_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic goto_t(input int t);
    repeat (t - tpos) @(negedge clk);
    tpos = t;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; strobe_req = 1'b0; brightness = 8'd30;
    repeat (3) @(negedge clk);
    chk("reset_col_idx", 32'(col_idx), 32'd0);
    chk("reset_onehot", 32'(col_onehot), 32'd0);
    chk("reset_drive", 32'(drive_en), 32'd0);
    chk("reset_swap", 32'(swap_pending), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    enable = 1'b1; tpos = -1;

    goto_t(0);
    chk("first_frame_start", 32'(frame_start), 32'd1);
    chk("first_col", 32'(col_idx), 32'd0);
    chk("blank_slot0", 32'(drive_en), 32'd0);
    goto_t(1);   chk("blank_slot1", 32'(drive_en), 32'd0);
    goto_t(2);   chk("on_slot2", 32'(drive_en), 32'd1);
    goto_t(31);  chk("on_slot31", 32'(drive_en), 32'd1);
    goto_t(32);  chk("col1_idx", 32'(col_idx), 32'd1);
                 chk("col1_blank", 32'(drive_en), 32'd0);
    goto_t(255); chk("col7_idx", 32'(col_idx), 32'd7);
    goto_t(256); chk("wrap_col", 32'(col_idx), 32'd0);
                 chk("wrap_frame", 32'(frame_start), 32'd1);
    brightness = 8'd5;

    goto_t(320); chk("b5_slot0_oh", 32'(col_onehot), 32'd0);
    goto_t(322); chk("b5_slot2_oh", 32'(col_onehot), 32'h04);
    goto_t(326); chk("b5_slot6_drv", 32'(drive_en), 32'd1);
    goto_t(327); chk("b5_slot7_drv", 32'(drive_en), 32'd0);
                 chk("b5_slot7_oh", 32'(col_onehot), 32'd0);
    brightness = 8'd0;
    goto_t(354); chk("b0_slot2", 32'(drive_en), 32'd0);

    goto_t(360); strobe_req = 1'b1; brightness = 8'd200;
    goto_t(361); strobe_req = 1'b0;
                 chk("strobe_pending", 32'(swap_pending), 32'd1);
                 chk("strobe_no_latch", 32'(latch_pulse), 32'd0);
    goto_t(386); chk("clamp_slot2_oh", 32'(col_onehot), 32'h10);
    goto_t(415); chk("clamp_slot31", 32'(drive_en), 32'd1);
    goto_t(511); chk("pending_hold", 32'(swap_pending), 32'd1);
    goto_t(512); chk("latch_at_frame", 32'(latch_pulse), 32'd1);
                 chk("latch_blanked", 32'(drive_en), 32'd0);
    goto_t(513); chk("latch_clears", 32'(swap_pending), 32'd0);
    latch_cnt = 0;

    goto_t(520); strobe_req = 1'b1;
    goto_t(521); strobe_req = 1'b0;
    goto_t(600); strobe_req = 1'b1;
    goto_t(601); strobe_req = 1'b0;
    goto_t(700); strobe_req = 1'b1;
    goto_t(701); strobe_req = 1'b0;
    goto_t(768); chk("multi_latch", 32'(latch_pulse), 32'd1);
    goto_t(800); chk("multi_latch_count", 32'(latch_cnt), 32'd1);
                 chk("multi_cleared", 32'(swap_pending), 32'd0);

    goto_t(900);  strobe_req = 1'b1;
    goto_t(901);  strobe_req = 1'b0;
    goto_t(1024); chk("coinc_latch", 32'(latch_pulse), 32'd1);
    strobe_req = 1'b1;
    goto_t(1025); strobe_req = 1'b0;
                  chk("coinc_keeps_pending", 32'(swap_pending), 32'd1);
    goto_t(1280); chk("coinc_second_latch", 32'(latch_pulse), 32'd1);
    goto_t(1281); chk("coinc_cleared", 32'(swap_pending), 32'd0);
    brightness = 8'd10;

    goto_t(1323); chk("b10_slot11", 32'(drive_en), 32'd1);
    goto_t(1324); chk("b10_slot12", 32'(drive_en), 32'd0);
    goto_t(1327); brightness = 8'd20;
    goto_t(1330); chk("b10_kept_slot18", 32'(drive_en), 32'd0);
    goto_t(1365); chk("b20_slot21", 32'(drive_en), 32'd1);
    goto_t(1366); chk("b20_slot22", 32'(drive_en), 32'd0);

    goto_t(1450); chk("pre_disable_oh", 32'(col_onehot), 32'h20);
    enable = 1'b0;
    goto_t(1451); chk("disable_drive", 32'(drive_en), 32'd0);
                  chk("disable_col", 32'(col_idx), 32'd0);
    strobe_req = 1'b1;
    goto_t(1452); strobe_req = 1'b0;
                  chk("disabled_strobe", 32'(swap_pending), 32'd1);
    goto_t(1455); enable = 1'b1; tpos = -1;
    goto_t(0);    chk("reenable_frame", 32'(frame_start), 32'd1);
                  chk("reenable_latch", 32'(latch_pulse), 32'd1);
                  chk("reenable_col", 32'(col_idx), 32'd0);
    goto_t(1);    chk("reenable_cleared", 32'(swap_pending), 32'd0);

    goto_t(35);   strobe_req = 1'b1;
    goto_t(36);   strobe_req = 1'b0;
    goto_t(40);   chk("pre_reset_oh", 32'(col_onehot), 32'h02);
                  chk("pre_reset_swap", 32'(swap_pending), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_drive", 32'(drive_en), 32'd0);
    chk("async_onehot", 32'(col_onehot), 32'd0);
    chk("async_swap", 32'(swap_pending), 32'd0);
    chk("async_col", 32'(col_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
